// File: rtl/universal_shift_reg_if.sv
// Bundles the control, serial and parallel signals of the universal shift register.
// master drives the controls and data; slave is the register itself.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH);

    logic             Clear;
    logic [1:0]       Mode;
    logic             ShiftInL;
    logic             ShiftInR;
    logic [WIDTH-1:0] ParallelIn;
    logic [WIDTH-1:0] ParallelOut;
    logic             ShiftOutL;
    logic             ShiftOutR;
    logic [CW-1:0]    BitCount;
    logic             FrameDone;

    modport master (
        output Clear, Mode, ShiftInL, ShiftInR, ParallelIn,
        input  ParallelOut, ShiftOutL, ShiftOutR, BitCount, FrameDone
    );

    modport slave (
        input  Clear, Mode, ShiftInL, ShiftInR, ParallelIn,
        output ParallelOut, ShiftOutL, ShiftOutR, BitCount, FrameDone
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, left/right shift and parallel load, with a
// shared frame counter that pulses FrameDone after every WIDTH shifts.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    universal_shift_reg_if.slave bus
);
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    count_adv_s;
    logic             frame_done_r;
    logic             frame_done_nxt_s;
    logic             frame_done_adv_s;

    // Counter step taken on any shift, wrapping at the frame boundary.
    always_comb begin
        count_adv_s      = count_r;
        frame_done_adv_s = 1'b0;
        if (count_r == CW'(WIDTH - 1)) begin
            count_adv_s      = {CW{1'b0}};
            frame_done_adv_s = 1'b1;
        end else begin
            count_adv_s      = count_r + CW'(1);
            frame_done_adv_s = 1'b0;
        end
    end

    // Next-state decode: Clear overrides Mode; serial inputs are only used by their own shift.
    always_comb begin
        shift_nxt_s      = shift_r;
        count_nxt_s      = count_r;
        frame_done_nxt_s = 1'b0;
        if (bus.Clear) begin
            shift_nxt_s      = {WIDTH{1'b0}};
            count_nxt_s      = {CW{1'b0}};
            frame_done_nxt_s = 1'b0;
        end else begin
            case (bus.Mode)
                2'b01: begin
                    shift_nxt_s      = {shift_r[WIDTH-2:0], bus.ShiftInL};
                    count_nxt_s      = count_adv_s;
                    frame_done_nxt_s = frame_done_adv_s;
                end
                2'b10: begin
                    shift_nxt_s      = {bus.ShiftInR, shift_r[WIDTH-1:1]};
                    count_nxt_s      = count_adv_s;
                    frame_done_nxt_s = frame_done_adv_s;
                end
                2'b11: begin
                    shift_nxt_s      = bus.ParallelIn;
                    count_nxt_s      = {CW{1'b0}};
                    frame_done_nxt_s = 1'b0;
                end
                default: begin
                    shift_nxt_s      = shift_r;
                    count_nxt_s      = count_r;
                    frame_done_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset to an empty, idle frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= {WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            shift_r      <= shift_nxt_s;
            count_r      <= count_nxt_s;
            frame_done_r <= frame_done_nxt_s;
        end
    end

    assign bus.ParallelOut = shift_r;
    assign bus.ShiftOutL   = shift_r[WIDTH-1];
    assign bus.ShiftOutR   = shift_r[0];
    assign bus.BitCount    = count_r;
    assign bus.FrameDone   = frame_done_r;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed scoreboard bench for universal_shift_reg at WIDTH=8: the driver queues
// hand-computed expectations, a monitor compares them one cycle after each edge.
module tb_universal_shift_reg;
    logic clk;
    logic rst_n;

    universal_shift_reg_if #(.WIDTH(8)) bus ();

    universal_shift_reg #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic [13:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   vec_count  = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected tuple: {ParallelOut, ShiftOutL, ShiftOutR, BitCount, FrameDone}
    function automatic logic [13:0] pack(input logic [7:0] po, input logic [2:0] bc, input logic fd);
        return {po, po[7], po[0], bc, fd};
    endfunction

    function automatic logic [13:0] observed();
        return {bus.ParallelOut, bus.ShiftOutL, bus.ShiftOutR, bus.BitCount, bus.FrameDone};
    endfunction

    function automatic void check(input string nm, input logic [13:0] act, input logic [13:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got po=%h sol=%b sor=%b bc=%0d fd=%b, want po=%h sol=%b sor=%b bc=%0d fd=%b",
                     nm, act[13:6], act[5], act[4], act[3:1], act[0],
                     exp[13:6], exp[5], exp[4], exp[3:1], exp[0]);
        end
    endfunction

    task automatic apply(input string nm, input logic clr, input logic [1:0] md,
                         input logic sil, input logic sir, input logic [7:0] pin,
                         input logic [7:0] po, input logic [2:0] bc, input logic fd);
        exp_t e;
        bus.Clear      = clr;
        bus.Mode       = md;
        bus.ShiftInL   = sil;
        bus.ShiftInR   = sir;
        bus.ParallelIn = pin;
        e.name = nm;
        e.exp  = pack(po, bc, fd);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one queued expectation per clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, observed(), e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] lbits;
        logic [7:0] ldes_po [8];
        logic [7:0] rser_po [8];
        logic [7:0] pri_po  [5];
        logic [7:0] pri_sil;
        logic [7:0] mid_po  [8];
        logic [7:0] b2b_po;

        lbits   = 8'b1011_0010;
        ldes_po = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
        rser_po = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
        pri_po  = '{8'h01, 8'h02, 8'h05, 8'h0A, 8'h15};
        pri_sil = 8'b0001_0101;
        mid_po  = '{8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};

        rst_n          = 1'b0;
        bus.Clear      = 1'b0;
        bus.Mode       = 2'b00;
        bus.ShiftInL   = 1'b0;
        bus.ShiftInR   = 1'b0;
        bus.ParallelIn = 8'h00;
        #1;
        check("reset_initial", observed(), pack(8'h00, 3'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Clear beats a simultaneous load of all-ones
        apply("clear_over_load", 1'b1, 2'b11, 1'b0, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0);

        // Left deserialise 1,0,1,1,0,0,1,0 -> B2 with a frame pulse
        for (int i = 0; i < 8; i++)
            apply("left_deser", 1'b0, 2'b01, lbits[7-i], 1'b0, 8'h00,
                  ldes_po[i], 3'(i + 1), (i == 7) ? 1'b1 : 1'b0);

        // Load on the cycle after the frame pulse, then serialise right
        apply("load_a5", 1'b0, 2'b11, 1'b0, 1'b0, 8'hA5, 8'hA5, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            apply("right_ser", 1'b0, 2'b10, 1'b0, 1'b0, 8'h00,
                  rser_po[i], 3'(i + 1), (i == 7) ? 1'b1 : 1'b0);

        // Three shifts then hold while ShiftInL toggles
        apply("hold_pre1", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 8'h01, 3'd1, 1'b0);
        apply("hold_pre2", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 8'h03, 3'd2, 1'b0);
        apply("hold_pre3", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 8'h07, 3'd3, 1'b0);
        for (int i = 0; i < 5; i++)
            apply("hold", 1'b0, 2'b00, i[0], 1'b1, 8'hFF, 8'h07, 3'd3, 1'b0);

        // Clear priority, then a mid-frame load restarts the count
        apply("clear_pri", 1'b1, 2'b11, 1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++)
            apply("pri_shift", 1'b0, 2'b01, pri_sil[4-i], 1'b0, 8'h00, pri_po[i], 3'(i + 1), 1'b0);
        apply("load_3c_mid", 1'b0, 2'b11, 1'b0, 1'b0, 8'h3C, 8'h3C, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            apply("post_load", 1'b0, 2'b01, 1'b0, 1'b0, 8'h00,
                  mid_po[i], 3'(i + 1), (i == 7) ? 1'b1 : 1'b0);
        apply("clear_after_frame", 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

        // 24 back-to-back shifts: pulses at 8, 16, 24
        for (int k = 1; k <= 24; k++) begin
            b2b_po = (k >= 8) ? 8'hFF : 8'((1 << k) - 1);
            apply("b2b", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00,
                  b2b_po, 3'(k % 8), ((k % 8) == 0) ? 1'b1 : 1'b0);
        end
        apply("b2b_hold", 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'hFF, 3'd0, 1'b0);

        // Asynchronous reset mid-frame while shifting
        apply("pre_rst1", 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'hFE, 3'd1, 1'b0);
        apply("pre_rst2", 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 8'hFC, 3'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", observed(), pack(8'h00, 3'd0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", observed(), pack(8'h00, 3'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 8'h01, 3'd1, 1'b0);
        apply("post_rst_hold", 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h01, 3'd1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule

// File: doc/universal_shift_reg.md
# universal_shift_reg

Parametrised universal shift register, the successor to the fixed 4-bit serial-in/parallel-out shifter. It supports hold, left shift, right shift and parallel load, with serial in and out in both directions. A frame counter pulses `FrameDone` after every WIDTH shifts, so a serial link can be deserialised or serialised one word at a time. It sits between a serial pin interface and word-wide datapath logic.

## Interface
- `WIDTH`, default 8: register width in bits, ≥ 2.
- `CW`, default `$clog2(WIDTH)`: width of the frame counter. It is derived and must not be overridden.

Ports:
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `Clear` input, 1 bit: synchronous clear of the register and the counter. It has priority over `Mode`.
- `Mode` input, 2 bits: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- `ShiftInL` input, 1 bit: serial input entering at bit 0 during a left shift.
- `ShiftInR` input, 1 bit: serial input entering at bit WIDTH-1 during a right shift.
- `ParallelIn` input, WIDTH bits: load data.
- `ParallelOut` output, WIDTH bits: register contents.
- `ShiftOutL` output, 1 bit: equals `ParallelOut[WIDTH-1]`, combinational.
- `ShiftOutR` output, 1 bit: equals `ParallelOut[0]`, combinational.
- `BitCount` output, CW bits: number of shifts since the last frame boundary, load, clear or reset.
- `FrameDone` output, 1 bit: registered one-cycle pulse.

## Operation
- Reset (`rst_n`=0, asynchronous):
  - `ParallelOut`=0, `BitCount`=0, `FrameDone`=0 immediately.
  - All state holds at these values while reset is asserted.
- Priority at each rising edge, highest first: `Clear`, then `Mode`.
- `Clear`=1: register ← 0, `BitCount` ← 0, `FrameDone` ← 0. `Mode` is ignored.
- `Mode`=00: register and `BitCount` hold; `FrameDone` ← 0.
- `Mode`=01: register ← {reg[WIDTH-2:0], `ShiftInL`}. The counter advances as described below.
- `Mode`=10: register ← {`ShiftInR`, reg[WIDTH-1:1]}. The counter advances as described below.
- `Mode`=11: register ← `ParallelIn`, `BitCount` ← 0, `FrameDone` ← 0.
- Counter on any shift (`Mode`=01 or 10):
  - If `BitCount` == WIDTH-1: `BitCount` ← 0 and `FrameDone` ← 1.
  - Otherwise: `BitCount` ← `BitCount`+1 and `FrameDone` ← 0.
- Left and right shifts share one counter. Mixing directions within a frame is legal and still counts every shift.
- The register updates only through nonblocking assignments. No bit of the register is written outside the `Mode`/`Clear` decode; in particular, `ShiftInL` is never sampled in hold mode.
- The counter wraps. There is no saturation and no overflow flag.

## Timing
- Latency is one clock from input sampling to `ParallelOut`, `BitCount` and `FrameDone`.
- `ShiftOutL` and `ShiftOutR` follow `ParallelOut` with zero extra latency.
- `FrameDone` is high for exactly the one cycle after the WIDTH-th shift. Continuous shifting therefore produces a pulse every WIDTH cycles.
- When the first shift of the next frame follows immediately, `FrameDone` drops on that edge while `BitCount` goes to 1.
- Load or clear on the cycle after the WIDTH-th shift: `FrameDone` still shows the pulse for that cycle, then clears.
- Reset asserted mid-frame: all state is lost, and counting restarts from 0 after release.
- `rst_n` deassertion must be synchronous to `clk`, which is the system's responsibility. The first active edge after release is a normal operating edge.

## Test plan
- Reset: drive `rst_n`=0 mid-operation with `Mode`=01 → `ParallelOut`=8'h00, `BitCount`=0 and `FrameDone`=0 without waiting for a clock edge; they stay there until release.
- Left deserialise (WIDTH=8): shift in 1,0,1,1,0,0,1,0 MSB-first with `Mode`=01 → after 8 edges `ParallelOut`=8'hB2, `FrameDone`=1 for one cycle, `BitCount`=0.
- Right serialise: load 8'hA5, then 8× `Mode`=10 with `ShiftInR`=0 → `ShiftOutR` sequence 1,0,1,0,0,1,0,1; final `ParallelOut`=8'h00; `FrameDone` pulses after the 8th shift.
- Hold: after 3 shifts with `BitCount`=3, hold for 5 cycles while toggling `ShiftInL` → `ParallelOut` and `BitCount` are unchanged and `FrameDone`=0.
- Priority: `Clear`=1 together with `Mode`=11 and `ParallelIn`=8'hFF → `ParallelOut`=8'h00 and `BitCount`=0. Then load 8'h3C mid-frame at `BitCount`=5 → `BitCount`=0, and no `FrameDone` until 8 further shifts.
- Back-to-back frames: 24 consecutive shifts → exactly 3 `FrameDone` pulses, at shifts 8, 16 and 24; `BitCount` wraps 7→0 each time.
